wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two writers:
  - the in-order ALU result leaving S3 (S3_ALUOut / S3_WriteSelect / S3_WriteEnable);
  - a multi-cycle unit (MC) that finishes out of order through a valid/ready handshake.
- The ALU always wins. MC results wait in a small FIFO.
- A wait counter forces a one-cycle pipeline stall so MC results cannot starve.
- Sits between the S3 stage register and the register file. It drives the final write-back signals.

Parameters:
- DEPTH, 2: MC holding FIFO entries (power of two, 2..8).
- MAX_WAIT, 4: cycles a valid FIFO head may wait before PipeStall is raised (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- S3_ALUOut  in  32  ALU result from S3
- S3_WriteSelect  in  5  ALU destination register
- S3_WriteEnable  in  1  ALU write request; held stable by upstream while PipeStall=1
- MC_Result  in  32  multi-cycle unit result
- MC_WriteSelect  in  5  multi-cycle destination register
- MC_Valid  in  1  MC result offered
- MC_Ready  out  1  FIFO can accept; MC handshake completes when MC_Valid & MC_Ready
- PipeStall  out  1  registered; freezes S1–S3 for exactly the cycle it is high
- WB_Data  out  32  register-file write data
- WB_WriteSelect  out  5  register-file write address
- WB_WriteEnable  out  1  register-file write strobe

Behaviour:
- All state and the WB_*/PipeStall outputs update on posedge clk. WB_* reflect the previous cycle's arbitration decision (1-cycle latency).
- Reset:
  - WB_Data=0, WB_WriteSelect=0, WB_WriteEnable=0, PipeStall=0.
  - FIFO count=0, all entry valid bits cleared, wait counter=0.
  - Reset mid-operation discards every buffered MC result; none is written.
- MC_Ready = (count != DEPTH). It is combinational from registered count only and does not look ahead to a same-cycle pop.
- FIFO entry = {data, select, live}. On accept, the entry is pushed at the tail with live=1, except as stated under the kill rule.
- Arbitration each cycle, in priority order:
  1. PipeStall=0 and S3_WriteEnable=1 → write the ALU value. No MC pop.
  2. Otherwise, head exists and is live → pop the head and write it. The wait counter clears.
  3. Otherwise, head exists and is dead → pop it with WB_WriteEnable=0 (no write).
  4. Otherwise, FIFO is empty and an MC accept occurs this cycle → cut-through: write the MC value directly; nothing is pushed.
  5. Otherwise → WB_WriteEnable=0. WB_Data and WB_WriteSelect hold their last values.
- During a PipeStall=1 cycle, S3 inputs are ignored. The same ALU write is performed in the following cycle.
- Dead-head pops (rule 3) may also occur in a cycle where rule 1 fires: at most one dead head is discarded per cycle, in parallel with the ALU write.
- Kill rule (WAW ordering; MC ops are older than the concurrent S3 op):
  - When rule 1 writes register R, every FIFO entry with select R is cleared to live=0.
  - An MC result accepted in the same cycle with select R is pushed with live=0. Cut-through does not apply because rule 1 took the port.
- Wait counter:
  - Increments each cycle a live head exists and is not popped.
  - Saturates at MAX_WAIT.
  - When the counter equals MAX_WAIT at a clock edge, PipeStall=1 for the next cycle only.
  - In that cycle rule 2 pops the head and the counter clears.
  - PipeStall never stays high two consecutive cycles. If a new live head still waits, counting restarts from 0.
- Simultaneous push and pop with count=DEPTH is impossible (MC_Ready=0). With 0<count<DEPTH, a push and a pop in the same cycle leave count unchanged.
- Pointers wrap modulo DEPTH.
- Register 0 is not special-cased.

Test Plan:
- ALU only: S3_WriteEnable=1, S3_WriteSelect=5, S3_ALUOut=0x1234 → next cycle WB_WriteEnable=1, WB_WriteSelect=5, WB_Data=0x1234. MC_Ready=1 throughout.
- Cut-through: FIFO empty, ALU idle, MC_Valid=1 with select 7, data 0xBEEF → next cycle write of reg 7, value 0xBEEF. Count stays 0.
- Starvation/stall (MAX_WAIT=4): ALU writes every cycle and one MC result is accepted → PipeStall=1 in exactly one cycle, when the counter hits 4 (5 cycles after the accept). The MC value is written the cycle after the stall. The held ALU write follows the next cycle. No ALU write is lost.
- Full FIFO (DEPTH=2): ALU busy, two MC accepts → MC_Ready=0. A third MC_Valid is held until a pop, then accepted. FIFO order is preserved on write-back.
- Kill: MC result for reg 3 buffered, then ALU writes reg 3 = 0xA → reg 3 is written only with 0xA. The dead entry is dropped with WB_WriteEnable=0 and no stall. Repeat with the MC accept and the ALU reg-3 write in the same cycle → same outcome.
- Reset mid-operation: two entries buffered and PipeStall pending, rst=1 for one cycle → all outputs 0, MC_Ready=1. No buffered value is ever written afterwards.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the S3 ALU result always wins, multi-cycle
// results queue in a small FIFO and force a one-cycle stall if left waiting.
module wb_port_arbiter #(
   parameter int DEPTH    = 2,
   parameter int MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] S3_ALUOut,
   input  logic [4:0]  S3_WriteSelect,
   input  logic        S3_WriteEnable,
   input  logic [31:0] MC_Result,
   input  logic [4:0]  MC_WriteSelect,
   input  logic        MC_Valid,
   output logic        MC_Ready,
   output logic        PipeStall,
   output logic [31:0] WB_Data,
   output logic [4:0]  WB_WriteSelect,
   output logic        WB_WriteEnable
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [31:0]      fifo_data [DEPTH];
   logic [4:0]       fifo_sel  [DEPTH];
   logic [DEPTH-1:0] fifo_live;
   logic [DEPTH-1:0] fifo_vld;
   logic [PW-1:0]    head_ptr;
   logic [PW-1:0]    tail_ptr;
   logic [CW-1:0]    count;
   logic [3:0]       wait_cnt;

   logic             alu_win;
   logic             head_vld;
   logic             head_live;
   logic             head_killed;
   logic             accept;
   logic             pop;
   logic             cut;
   logic             push;
   logic             push_live;
   logic [3:0]       wait_d;
   logic             stall_d;
   logic [31:0]      wb_data_d;
   logic [4:0]       wb_sel_d;
   logic             wb_we_d;

   // Ready looks only at the registered occupancy, never at a same-cycle pop.
   assign MC_Ready = (count != CW'(DEPTH));

   always_comb begin
      alu_win     = ~PipeStall & S3_WriteEnable;
      head_vld    = fifo_vld[head_ptr];
      head_live   = head_vld & fifo_live[head_ptr];
      head_killed = alu_win & (fifo_sel[head_ptr] == S3_WriteSelect);
      accept      = MC_Valid & MC_Ready;
      // A dead head is dropped even while the ALU owns the port.
      pop         = head_vld & (~alu_win | ~fifo_live[head_ptr]);
      cut         = ~alu_win & ~head_vld & accept;
      push        = accept & ~cut;
      // The MC op is older than the concurrent S3 op, so a same-register
      // result must never reach the register file after the ALU write.
      push_live   = ~(alu_win & (MC_WriteSelect == S3_WriteSelect));
   end

   always_comb begin
      wait_d = 4'd0;
      if (head_live & ~pop & ~head_killed) begin
         if (wait_cnt == 4'(MAX_WAIT))
            wait_d = wait_cnt;
         else
            wait_d = wait_cnt + 4'd1;
      end
      stall_d = (wait_d == 4'(MAX_WAIT)) & ~PipeStall;
   end

   always_comb begin
      wb_we_d   = 1'b0;
      wb_data_d = WB_Data;
      wb_sel_d  = WB_WriteSelect;
      if (alu_win) begin
         wb_we_d   = 1'b1;
         wb_data_d = S3_ALUOut;
         wb_sel_d  = S3_WriteSelect;
      end else if (head_live) begin
         wb_we_d   = 1'b1;
         wb_data_d = fifo_data[head_ptr];
         wb_sel_d  = fifo_sel[head_ptr];
      end else if (~head_vld & accept) begin
         wb_we_d   = 1'b1;
         wb_data_d = MC_Result;
         wb_sel_d  = MC_WriteSelect;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         WB_Data        <= '0;
         WB_WriteSelect <= '0;
         WB_WriteEnable <= 1'b0;
         PipeStall      <= 1'b0;
         wait_cnt       <= '0;
         count          <= '0;
         head_ptr       <= '0;
         tail_ptr       <= '0;
         fifo_live      <= '0;
         fifo_vld       <= '0;
      end else begin
         WB_Data        <= wb_data_d;
         WB_WriteSelect <= wb_sel_d;
         WB_WriteEnable <= wb_we_d;
         PipeStall      <= stall_d;
         wait_cnt       <= wait_d;
         count          <= count + CW'(push) - CW'(pop);
         for (int i = 0; i < DEPTH; i++) begin
            if (alu_win && (fifo_sel[i] == S3_WriteSelect))
               fifo_live[i] <= 1'b0;
         end
         if (pop) begin
            fifo_vld[head_ptr]  <= 1'b0;
            fifo_live[head_ptr] <= 1'b0;
            head_ptr            <= head_ptr + PW'(1);
         end
         if (push) begin
            fifo_vld[tail_ptr]  <= 1'b1;
            fifo_live[tail_ptr] <= push_live;
            tail_ptr            <= tail_ptr + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[tail_ptr] <= MC_Result;
         fifo_sel[tail_ptr]  <= MC_WriteSelect;
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] S3_ALUOut;
   logic [4:0]  S3_WriteSelect;
   logic        S3_WriteEnable;
   logic [31:0] MC_Result;
   logic [4:0]  MC_WriteSelect;
   logic        MC_Valid;
   logic        MC_Ready;
   logic        PipeStall;
   logic [31:0] WB_Data;
   logic [4:0]  WB_WriteSelect;
   logic        WB_WriteEnable;

   int errors = 0;
   int checks = 0;

   wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk(clk), .rst(rst),
      .S3_ALUOut(S3_ALUOut), .S3_WriteSelect(S3_WriteSelect), .S3_WriteEnable(S3_WriteEnable),
      .MC_Result(MC_Result), .MC_WriteSelect(MC_WriteSelect), .MC_Valid(MC_Valid),
      .MC_Ready(MC_Ready), .PipeStall(PipeStall),
      .WB_Data(WB_Data), .WB_WriteSelect(WB_WriteSelect), .WB_WriteEnable(WB_WriteEnable)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      S3_ALUOut = '0; S3_WriteSelect = '0; S3_WriteEnable = 1'b0;
      MC_Result = '0; MC_WriteSelect = '0; MC_Valid = 1'b0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++; if (WB_WriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", WB_WriteEnable); end
      checks++; if (WB_Data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", WB_Data); end
      checks++; if (WB_WriteSelect !== 5'd0) begin errors++; $display("FAIL reset_sel got %0d want 0", WB_WriteSelect); end
      checks++; if (PipeStall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", PipeStall); end
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", MC_Ready); end
   endtask

   task automatic test_alu_only();
      S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd5; S3_ALUOut = 32'h1234;
      tick();
      idle_inputs();
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd5 || WB_Data !== 32'h1234) begin
         errors++; $display("FAIL alu_write got we=%0b sel=%0d data=%h want 1/5/00001234", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL alu_ready got %0b want 1", MC_Ready); end
      tick();
      checks++; if (WB_WriteEnable !== 1'b0 || WB_Data !== 32'h1234 || WB_WriteSelect !== 5'd5) begin
         errors++; $display("FAIL alu_hold got we=%0b sel=%0d data=%h want 0/5/00001234", WB_WriteEnable, WB_WriteSelect, WB_Data); end
   endtask

   task automatic test_cut_through();
      MC_Valid = 1'b1; MC_WriteSelect = 5'd7; MC_Result = 32'hBEEF;
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL cut_ready_pre got %0b want 1", MC_Ready); end
      tick();
      idle_inputs();
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd7 || WB_Data !== 32'hBEEF) begin
         errors++; $display("FAIL cut_write got we=%0b sel=%0d data=%h want 1/7/0000beef", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      tick();
      checks++; if (WB_WriteEnable !== 1'b0) begin errors++; $display("FAIL cut_nopush got we=%0b want 0", WB_WriteEnable); end
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL cut_ready_post got %0b want 1", MC_Ready); end
   endtask

   task automatic test_starvation();
      int stalls;
      logic [31:0] exp_d;
      stalls = 0;
      S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd10;
      MC_Valid = 1'b1; MC_WriteSelect = 5'd12; MC_Result = 32'hC0DE;
      for (int k = 0; k < 5; k++) begin
         S3_ALUOut = 32'h100 + k;
         exp_d = 32'h100 + k;
         tick();
         MC_Valid = 1'b0;
         if (PipeStall === 1'b1) stalls++;
         checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd10 || WB_Data !== exp_d) begin
            errors++; $display("FAIL starve_alu%0d got we=%0b sel=%0d data=%h want 1/10/%h", k, WB_WriteEnable, WB_WriteSelect, WB_Data, exp_d); end
         checks++; if (PipeStall !== (k == 4)) begin
            errors++; $display("FAIL starve_stall%0d got %0b want %0b", k, PipeStall, (k == 4)); end
      end
      S3_ALUOut = 32'h105;
      tick();
      if (PipeStall === 1'b1) stalls++;
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd12 || WB_Data !== 32'hC0DE) begin
         errors++; $display("FAIL starve_mc got we=%0b sel=%0d data=%h want 1/12/0000c0de", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      tick();
      if (PipeStall === 1'b1) stalls++;
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd10 || WB_Data !== 32'h105) begin
         errors++; $display("FAIL starve_held got we=%0b sel=%0d data=%h want 1/10/00000105", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      idle_inputs();
      tick();
      if (PipeStall === 1'b1) stalls++;
      checks++; if (WB_WriteEnable !== 1'b0) begin errors++; $display("FAIL starve_idle got we=%0b want 0", WB_WriteEnable); end
      checks++; if (stalls !== 1) begin errors++; $display("FAIL starve_count got %0d stall cycles want 1", stalls); end
   endtask

   task automatic test_full();
      S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd20; S3_ALUOut = 32'h2020;
      MC_Valid = 1'b1; MC_WriteSelect = 5'd1; MC_Result = 32'h11;
      tick();
      MC_WriteSelect = 5'd2; MC_Result = 32'h22;
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL full_ready1 got %0b want 1", MC_Ready); end
      tick();
      checks++; if (MC_Ready !== 1'b0) begin errors++; $display("FAIL full_ready0 got %0b want 0", MC_Ready); end
      checks++; if (WB_WriteEnable !== 1'b1 || WB_Data !== 32'h2020) begin
         errors++; $display("FAIL full_alu got we=%0b data=%h want 1/00002020", WB_WriteEnable, WB_Data); end
      S3_WriteEnable = 1'b0;
      MC_WriteSelect = 5'd3; MC_Result = 32'h33;
      tick();
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd1 || WB_Data !== 32'h11) begin
         errors++; $display("FAIL full_pop1 got we=%0b sel=%0d data=%h want 1/1/00000011", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %0b want 1", MC_Ready); end
      tick();
      MC_Valid = 1'b0;
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd2 || WB_Data !== 32'h22) begin
         errors++; $display("FAIL full_pop2 got we=%0b sel=%0d data=%h want 1/2/00000022", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      tick();
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd3 || WB_Data !== 32'h33) begin
         errors++; $display("FAIL full_pop3 got we=%0b sel=%0d data=%h want 1/3/00000033", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      idle_inputs();
      tick();
      checks++; if (WB_WriteEnable !== 1'b0 || PipeStall !== 1'b0) begin
         errors++; $display("FAIL full_drain got we=%0b stall=%0b want 0/0", WB_WriteEnable, PipeStall); end
   endtask

   task automatic test_kill();
      // MC result buffered first, then killed by a later ALU write.
      S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd9; S3_ALUOut = 32'h99;
      MC_Valid = 1'b1; MC_WriteSelect = 5'd3; MC_Result = 32'hDEAD;
      tick();
      MC_Valid = 1'b0;
      S3_WriteSelect = 5'd3; S3_ALUOut = 32'hA;
      tick();
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd3 || WB_Data !== 32'hA) begin
         errors++; $display("FAIL kill_alu got we=%0b sel=%0d data=%h want 1/3/0000000a", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      idle_inputs();
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (WB_WriteEnable !== 1'b0 || PipeStall !== 1'b0 || WB_Data !== 32'hA) begin
            errors++; $display("FAIL kill_drop%0d got we=%0b stall=%0b data=%h want 0/0/0000000a", k, WB_WriteEnable, PipeStall, WB_Data); end
      end
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL kill_empty got ready=%0b want 1", MC_Ready); end
      // Same-cycle accept and ALU write to the same register.
      S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd3; S3_ALUOut = 32'hA;
      MC_Valid = 1'b1; MC_WriteSelect = 5'd3; MC_Result = 32'hDEAD;
      tick();
      idle_inputs();
      checks++; if (WB_WriteEnable !== 1'b1 || WB_WriteSelect !== 5'd3 || WB_Data !== 32'hA) begin
         errors++; $display("FAIL kill2_alu got we=%0b sel=%0d data=%h want 1/3/0000000a", WB_WriteEnable, WB_WriteSelect, WB_Data); end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (WB_WriteEnable !== 1'b0 || PipeStall !== 1'b0 || WB_Data !== 32'hA) begin
            errors++; $display("FAIL kill2_drop%0d got we=%0b stall=%0b data=%h want 0/0/0000000a", k, WB_WriteEnable, PipeStall, WB_Data); end
      end
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL kill2_empty got ready=%0b want 1", MC_Ready); end
   endtask

   task automatic test_reset_mid();
      S3_WriteEnable = 1'b1; S3_WriteSelect = 5'd20; S3_ALUOut = 32'h2020;
      MC_Valid = 1'b1; MC_WriteSelect = 5'd4; MC_Result = 32'h44;
      tick();
      MC_WriteSelect = 5'd5; MC_Result = 32'h55;
      tick();
      MC_Valid = 1'b0;
      tick(); tick();
      checks++; if (MC_Ready !== 1'b0) begin errors++; $display("FAIL rmid_full got ready=%0b want 0", MC_Ready); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      checks++; if (WB_WriteEnable !== 1'b0 || WB_Data !== 32'h0 || WB_WriteSelect !== 5'd0 || PipeStall !== 1'b0) begin
         errors++; $display("FAIL rmid_outputs got we=%0b data=%h sel=%0d stall=%0b want all 0", WB_WriteEnable, WB_Data, WB_WriteSelect, PipeStall); end
      checks++; if (MC_Ready !== 1'b1) begin errors++; $display("FAIL rmid_ready got %0b want 1", MC_Ready); end
      for (int k = 0; k < 6; k++) begin
         tick();
         checks++; if (WB_WriteEnable !== 1'b0 || PipeStall !== 1'b0) begin
            errors++; $display("FAIL rmid_quiet%0d got we=%0b stall=%0b want 0/0", k, WB_WriteEnable, PipeStall); end
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_alu_only();
      test_cut_through();
      tick();
      test_starvation();
      tick();
      test_full();
      tick();
      test_kill();
      tick();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
